// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch next-PC generator and its prediction queue.
package fetch_pc_gen_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_next;
  } pred_entry_t;

  function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_pred_fifo.sv
// In-order queue of fetched PCs and their predicted next PCs; synchronous clear beats push/pop.
module fetch_pc_gen_pred_fifo
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  pred_entry_t wdata,
  output pred_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  pred_entry_t     mem_q [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full  = (cnt_q == CntW'(QDEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue may still accept a push
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: follows btb predictions, checks them at resolve, redirects on miss.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] btb_target_pc,
  input  logic            btb_valid,
  input  logic            btb_predicted_taken,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            resolve_valid,
  input  logic            resolve_is_branch,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  output logic            btb_update,
  output logic [XLEN-1:0] btb_update_pc,
  output logic [XLEN-1:0] btb_update_target,
  output logic            btb_mispredicted,
  output logic            flush,
  output logic            q_full
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] upd_pc_q, upd_pc_d;
  logic [XLEN-1:0] upd_tgt_q, upd_tgt_d;
  logic            upd_q, upd_d;
  logic            mis_q, mis_d;
  logic            flush_q, flush_d;

  pred_entry_t     head, push_entry;
  logic            fifo_full, fifo_empty;
  logic            resolve_acc, pred_taken, mispredict;
  logic [XLEN-1:0] pred_next, actual_next;

  fetch_pc_gen_pred_fifo #(
    .QDEPTH(QDEPTH)
  ) u_pred_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(mispredict),
    .push (fetch_valid),
    .pop  (resolve_acc),
    .wdata(push_entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    pred_taken  = btb_valid & btb_predicted_taken;
    pred_next   = pred_taken ? btb_target_pc : seq_next(fetch_pc_q);
    resolve_acc = resolve_valid & ~fifo_empty;
    actual_next = (resolve_is_branch & resolve_taken) ? resolve_target : seq_next(head.pc);
    // Every entry is checked, so a btb alias on a non-branch is caught too
    mispredict  = resolve_acc & (actual_next != head.pred_next);
    fetch_valid = ~stall & (~fifo_full | resolve_acc) & ~mispredict;
    push_entry  = '{pc: fetch_pc_q, pred_next: pred_next};

    fetch_pc_d = fetch_pc_q;
    if (mispredict)       fetch_pc_d = actual_next;
    else if (fetch_valid) fetch_pc_d = pred_next;

    upd_d     = resolve_acc & resolve_is_branch & (resolve_taken | mispredict);
    mis_d     = mispredict;
    flush_d   = mispredict;
    upd_pc_d  = upd_d ? head.pc : upd_pc_q;
    upd_tgt_d = upd_d ? resolve_target : upd_tgt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      upd_q      <= 1'b0;
      mis_q      <= 1'b0;
      flush_q    <= 1'b0;
      upd_pc_q   <= '0;
      upd_tgt_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      upd_q      <= upd_d;
      mis_q      <= mis_d;
      flush_q    <= flush_d;
      upd_pc_q   <= upd_pc_d;
      upd_tgt_q  <= upd_tgt_d;
    end
  end

  assign fetch_pc          = fetch_pc_q;
  assign btb_update        = upd_q;
  assign btb_update_pc     = upd_pc_q;
  assign btb_update_target = upd_tgt_q;
  assign btb_mispredicted  = mis_q;
  assign flush             = flush_q;
  assign q_full            = fifo_full;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: queue-level reference model feeds expected fetches/btb events.
module tb_fetch_pc_gen;

  localparam int unsigned QD = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, btb_valid, btb_predicted_taken;
  logic [31:0] btb_target_pc;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        resolve_valid, resolve_is_branch, resolve_taken;
  logic [31:0] resolve_target;
  logic        btb_update, btb_mispredicted, flush, q_full;
  logic [31:0] btb_update_pc, btb_update_target;

  fetch_pc_gen #(
    .RESET_PC(RST_PC),
    .QDEPTH  (QD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .btb_target_pc      (btb_target_pc),
    .btb_valid          (btb_valid),
    .btb_predicted_taken(btb_predicted_taken),
    .fetch_pc           (fetch_pc),
    .fetch_valid        (fetch_valid),
    .resolve_valid      (resolve_valid),
    .resolve_is_branch  (resolve_is_branch),
    .resolve_taken      (resolve_taken),
    .resolve_target     (resolve_target),
    .btb_update         (btb_update),
    .btb_update_pc      (btb_update_pc),
    .btb_update_target  (btb_update_target),
    .btb_mispredicted   (btb_mispredicted),
    .flush              (flush),
    .q_full             (q_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        mis;
    logic        fl;
  } ev_t;

  // Reference model state: in-flight queue, fetch PC, held btb update fields
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] hold_pc, hold_tgt;

  logic [31:0] fetch_q[$];
  ev_t         ev_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = RST_PC;
    hold_pc  = '0;
    hold_tgt = '0;
  endtask

  // Drive one cycle of inputs, advance the model, push expectations, then step past the edge.
  task automatic cycle(input logic st, input logic bv, input logic bt, input logic [31:0] btgt,
                       input logic rv, input logic rb, input logic rt, input logic [31:0] rtgt);
    ent_t        h;
    logic        acc, mis, upd, fv, room;
    logic [31:0] actual, pred;
    ev_t         e;
    stall = st; btb_valid = bv; btb_predicted_taken = bt; btb_target_pc = btgt;
    resolve_valid = rv; resolve_is_branch = rb; resolve_taken = rt; resolve_target = rtgt;
    acc = rv && (mq.size() != 0);
    mis = 1'b0; upd = 1'b0; actual = '0; h = '{pc: '0, pred: '0};
    if (acc) begin
      h      = mq[0];
      actual = (rb && rt) ? rtgt : h.pc + 32'd4;
      mis    = (actual != h.pred);
      upd    = rb && (rt || mis);
    end
    room = (mq.size() < QD) || (acc && !mis);
    fv   = !st && room && !mis;
    pred = (bv && bt) ? btgt : m_pc + 32'd4;
    if (fv) fetch_q.push_back(m_pc);
    if (acc && (upd || mis)) begin
      if (upd) begin
        hold_pc  = h.pc;
        hold_tgt = rtgt;
      end
      e = '{upd: upd, pc: hold_pc, tgt: hold_tgt, mis: mis, fl: mis};
      ev_q.push_back(e);
    end
    if (acc) void'(mq.pop_front());
    if (mis) begin
      mq.delete();
      m_pc = actual;
    end else if (fv) begin
      mq.push_back('{pc: m_pc, pred: pred});
      m_pc = pred;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (fetch_valid) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", fetch_pc, 32'hxxxx_xxxx);
        else chk("fetch_pc", fetch_pc, fetch_q.pop_front());
      end
      if (btb_update || btb_mispredicted || flush) begin
        if (ev_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL btb_event_unexpected: got upd=%b mis=%b flush=%b expected none",
                   btb_update, btb_mispredicted, flush);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          n_checks++;
          if (btb_update !== e.upd || btb_update_pc !== e.pc || btb_update_target !== e.tgt ||
              btb_mispredicted !== e.mis || flush !== e.fl) begin
            n_fail++;
            $display("FAIL btb_event: got upd=%b pc=%h tgt=%h mis=%b fl=%b expected upd=%b pc=%h tgt=%h mis=%b fl=%b",
                     btb_update, btb_update_pc, btb_update_target, btb_mispredicted, flush,
                     e.upd, e.pc, e.tgt, e.mis, e.fl);
          end
        end
      end
    end
  end

  initial begin
    logic        st, bv, bt, rv, rb, rt;
    logic [31:0] btgt, rtgt, bad;
    rst = 1'b1;
    stall = 1'b0; btb_valid = 1'b0; btb_predicted_taken = 1'b0; btb_target_pc = '0;
    resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_fetch_pc", fetch_pc, RST_PC);
    chk("reset_q_full", 32'(q_full), 32'd0);
    chk("reset_btb_update", 32'(btb_update), 32'd0);
    chk("reset_mispredicted", 32'(btb_mispredicted), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_update_pc", btb_update_pc, 32'd0);
    chk("reset_update_target", btb_update_target, 32'd0);

    // Sequential fetch 0,4,8
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("seq_fetch_pc", fetch_pc, 32'h0000_000C);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h000A_0000);

    // Correct taken prediction
    cycle(1'b0, 1'b1, 1'b1, 32'h000A_0020, 1'b0, 1'b0, 1'b0, '0);
    chk("taken_fetch_pc", fetch_pc, 32'h000A_0020);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h000A_0020);
    chk("taken_btb_update", 32'(btb_update), 32'd1);
    chk("taken_mispredicted", 32'(btb_mispredicted), 32'd0);
    chk("taken_flush", 32'(flush), 32'd0);
    chk("taken_update_pc", btb_update_pc, 32'h000A_0000);

    // Missed branch
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h000B_0000);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h000B_0020);
    chk("miss_flush", 32'(flush), 32'd1);
    chk("miss_fetch_pc", fetch_pc, 32'h000B_0020);
    chk("miss_btb_update", 32'(btb_update), 32'd1);
    chk("miss_update_pc", btb_update_pc, 32'h000B_0000);
    chk("miss_mispredicted", 32'(btb_mispredicted), 32'd1);

    // Wrong taken prediction
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h000C_0000);
    cycle(1'b0, 1'b1, 1'b1, 32'h000D_0020, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h0000_0000);
    chk("wrong_fetch_pc", fetch_pc, 32'h000C_0004);
    chk("wrong_flush", 32'(flush), 32'd1);
    chk("wrong_btb_update", 32'(btb_update), 32'd1);
    chk("wrong_mispredicted", 32'(btb_mispredicted), 32'd1);

    // Fill the queue, then push+pop while full
    repeat (QD) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("full_q_full", 32'(q_full), 32'd1);
    chk("full_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("full_fetch_pc", fetch_pc, 32'h000C_0014);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("pushpop_q_full", 32'(q_full), 32'd1);
    chk("pushpop_fetch_pc", fetch_pc, 32'h000C_0018);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("full_hold_pc", fetch_pc, 32'h000C_0018);

    // Drain, then resolve on an empty queue
    repeat (QD) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("drained_q_full", 32'(q_full), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h0012_3400);
    chk("empty_resolve_update", 32'(btb_update), 32'd0);
    chk("empty_resolve_mis", 32'(btb_mispredicted), 32'd0);
    chk("empty_resolve_flush", 32'(flush), 32'd0);
    chk("empty_resolve_pc", fetch_pc, 32'h000C_0018);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      st   = ($urandom_range(0, 3) == 0);
      bv   = $urandom_range(0, 1) != 0;
      bt   = $urandom_range(0, 1) != 0;
      btgt = rnd_tgt();
      rv = 1'b0; rb = 1'b0; rt = 1'b0; rtgt = rnd_tgt();
      if ($urandom_range(0, 2) != 0) begin
        rv = 1'b1;
        rb = $urandom_range(0, 1) != 0;
        rt = $urandom_range(0, 1) != 0;
        if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
          if (mq[0].pred == mq[0].pc + 32'd4) begin
            rt = 1'b0;
          end else begin
            rb = 1'b1; rt = 1'b1; rtgt = mq[0].pred;
          end
        end
      end
      cycle(st, bv, bt, btgt, rv, rb, rt, rtgt);
    end

    // Reset asserted while a flush pulse is showing
    if (mq.size() == 0) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    bad = mq[0].pred ^ 32'h0000_0100;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, bad);
    chk("pre_reset_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_fetch_pc", fetch_pc, RST_PC);
    chk("rst_btb_update", 32'(btb_update), 32'd0);
    chk("rst_q_full", 32'(q_full), 32'd0);
    ev_q.delete();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("post_reset_fetch_pc", fetch_pc, RST_PC + 32'd12);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    @(negedge clk);
    #1;
    chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    chk("event_queue_drained", 32'(ev_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
